// File: rtl/gray_enc_arbiter_if.sv
// gray_enc_arbiter_if: requester, grant and Gray-coded output bus of the shared encoder
interface gray_enc_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 3,
  parameter int IDW   = 2,
  parameter int CW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    grant;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic [IDW-1:0]      out_id;
  logic                out_ready;
  logic                busy;
  logic [CW-1:0]       xfer_cnt;
  modport master (
    output req, req_data, out_ready,
    input  grant, out_valid, out_data, out_id, busy, xfer_cnt
  );
  modport slave (
    input  req, req_data, out_ready,
    output grant, out_valid, out_data, out_id, busy, xfer_cnt
  );
endinterface

// File: rtl/gray_enc_arbiter.sv
// gray_enc_arbiter: round-robin arbiter sharing one binary-to-Gray encoder among N_REQ requesters
module gray_enc_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 3,
  parameter int IDW   = 2,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_enc_arbiter_if.slave   bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t         state;
  logic [IDW-1:0] ptr, win;
  logic           found, accept, next_valid;
  logic [DW-1:0]  lane;
  // descending scan so the lowest offset from ptr wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(ptr) + k) % N_REQ]) begin
        win   = IDW'((int'(ptr) + k) % N_REQ);
        found = 1'b1;
      end
    end
  end
  assign accept        = found && (state == EMPTY || bus.out_ready);
  assign next_valid    = accept || (state == FULL && !bus.out_ready);
  assign lane          = bus.req_data[int'(win)*DW +: DW];
  assign bus.grant     = (accept && rst_n) ? (N_REQ'(1) << win) : '0;
  assign bus.out_valid = state == FULL;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      bus.out_data <= '0;
      bus.out_id   <= '0;
      bus.busy     <= 1'b0;
      bus.xfer_cnt <= '0;
      ptr          <= '0;
    end else begin
      state    <= next_valid ? FULL : EMPTY;
      bus.busy <= (|bus.req) || next_valid;
      if (accept) begin
        bus.out_data <= lane ^ (lane >> 1);
        bus.out_id   <= win;
        ptr          <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
        bus.xfer_cnt <= bus.xfer_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gray_enc_arbiter.sv
// tb_gray_enc_arbiter: directed vectors with hand-computed expectations for gray_enc_arbiter
module tb_gray_enc_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  gray_enc_arbiter_if #(.N_REQ(4), .DW(3), .IDW(2), .CW(8)) bus ();
  gray_enc_arbiter #(.N_REQ(4), .DW(3), .IDW(2), .CW(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n         = 1'b0;
    bus.req       = 4'b1111;
    bus.req_data  = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", bus.grant, 4'b0000);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_data", bus.out_data, 3'b000);
    check("rst_cnt", bus.xfer_cnt, 8'd0);
    check("rst_busy", bus.busy, 1'b0);
    bus.req = 4'b0000;
    rst_n   = 1'b1;
    cyc();
    check("idle_valid", bus.out_valid, 1'b0);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_data", bus.out_data, 3'b000);
    bus.req = 4'b0100;
    for (int v = 0; v < 8; v++) begin
      bus.req_data = {3'd0, 3'(v), 3'd0, 3'd0};
      #1;
      check("tab_grant", bus.grant, 4'b0100);
      cyc();
      check("tab_data", bus.out_data, gtab[v]);
      check("tab_id", bus.out_id, 2'd2);
      check("tab_valid", bus.out_valid, 1'b1);
    end
    check("tab_cnt", bus.xfer_cnt, 8'd8);
    bus.req = 4'b0000;
    cyc();
    check("drain_valid", bus.out_valid, 1'b0);
    check("drain_busy", bus.busy, 1'b0);
    bus.req      = 4'b0101;
    bus.req_data = {3'd0, 3'd3, 3'd0, 3'd2};
    #1;
    check("wrap_g0", bus.grant, 4'b0001);
    cyc();
    check("wrap_id0", bus.out_id, 2'd0);
    check("wrap_d0", bus.out_data, 3'b011);
    check("wrap_g1", bus.grant, 4'b0100);
    cyc();
    check("wrap_id1", bus.out_id, 2'd2);
    check("wrap_d1", bus.out_data, 3'b010);
    check("wrap_g2", bus.grant, 4'b0001);
    cyc();
    check("wrap_id2", bus.out_id, 2'd0);
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_cnt", bus.xfer_cnt, 8'd0);
    check("arst_grant", bus.grant, 4'b0000);
    #1;
    rst_n         = 1'b1;
    bus.req       = 4'b1111;
    bus.req_data  = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.out_ready = 1'b1;
    #1;
    check("rr_g0", bus.grant, 4'b0001);
    cyc();
    check("rr_d0", bus.out_data, 3'b001);
    check("rr_g1", bus.grant, 4'b0010);
    cyc();
    check("rr_d1", bus.out_data, 3'b011);
    check("rr_g2", bus.grant, 4'b0100);
    cyc();
    check("rr_d2", bus.out_data, 3'b010);
    check("rr_g3", bus.grant, 4'b1000);
    cyc();
    check("rr_d3", bus.out_data, 3'b110);
    check("rr_g4", bus.grant, 4'b0001);
    cyc();
    check("rr_d4", bus.out_data, 3'b001);
    check("rr_id4", bus.out_id, 2'd0);
    check("rr_cnt", bus.xfer_cnt, 8'd5);
    bus.req      = 4'b0010;
    bus.req_data = {3'd0, 3'd0, 3'd5, 3'd0};
    #1;
    check("bp_g", bus.grant, 4'b0010);
    cyc();
    check("bp_d", bus.out_data, 3'b111);
    bus.req       = 4'b0011;
    bus.req_data  = {3'd0, 3'd0, 3'd5, 3'd6};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_grant", bus.grant, 4'b0000);
      cyc();
      check("stall_data", bus.out_data, 3'b111);
      check("stall_id", bus.out_id, 2'd1);
      check("stall_valid", bus.out_valid, 1'b1);
      check("stall_busy", bus.busy, 1'b1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("resume_grant", bus.grant, 4'b0001);
    cyc();
    check("resume_data", bus.out_data, 3'b101);
    check("resume_id", bus.out_id, 2'd0);
    check("resume_valid", bus.out_valid, 1'b1);
    check("resume_cnt", bus.xfer_cnt, 8'd7);
    bus.req = 4'b0001;
    repeat (248) cyc();
    check("cnt_max", bus.xfer_cnt, 8'd255);
    cyc();
    check("cnt_wrap", bus.xfer_cnt, 8'd0);
    bus.req = 4'b0000;
    cyc();
    check("end_valid", bus.out_valid, 1'b0);
    check("end_busy", bus.busy, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
